// File: rtl/polyphase_interp_4.sv
// 1:4 polyphase interpolator for a fixed 16-tap symmetric FIR.
// One multiply-accumulate per cycle; each output phase is held until y_ready accepts it.
module polyphase_interp_4 #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [W_IN-1:0]  X,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic signed [W_OUT-1:0] Y,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [1:0]              phase
);

  localparam int W_COEF = 7;
  localparam int W_PROD = W_IN + W_COEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic signed [W_IN-1:0]   d [4];
  logic signed [W_OUT-1:0]  acc;
  logic [1:0]               tap;
  logic signed [W_PROD-1:0] prod;
  logic signed [W_OUT-1:0]  acc_sum;

  // Coefficient index is 4*tap+phase, i.e. {tap, phase}.
  function automatic logic signed [W_COEF-1:0] coef(input logic [3:0] idx);
    case (idx)
      4'd0:  coef = -7'sd1;
      4'd1:  coef = -7'sd2;
      4'd2:  coef =  7'sd0;
      4'd3:  coef =  7'sd6;
      4'd4:  coef =  7'sd14;
      4'd5:  coef =  7'sd24;
      4'd6:  coef =  7'sd33;
      4'd7:  coef =  7'sd38;
      4'd8:  coef =  7'sd38;
      4'd9:  coef =  7'sd33;
      4'd10: coef =  7'sd24;
      4'd11: coef =  7'sd14;
      4'd12: coef =  7'sd6;
      4'd13: coef =  7'sd0;
      4'd14: coef = -7'sd2;
      4'd15: coef = -7'sd1;
    endcase
  endfunction

  assign prod    = W_PROD'(d[tap]) * W_PROD'(coef({tap, phase}));
  assign acc_sum = acc + W_OUT'(prod);

  // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (x_valid) state_nxt = MAC;
      MAC:     if (tap == 2'd3) state_nxt = OUT;
      OUT:     if (y_ready) state_nxt = (phase == 2'd3) ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_ready = (state == IDLE);
    y_valid = (state == OUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the delay line is reset too, so the first sample after reset sees zero history.
      for (int k = 0; k < 4; k++) d[k] <= '0;
      acc   <= '0;
      tap   <= '0;
      phase <= '0;
      Y     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (x_valid) begin
            d[0] <= X;
            for (int k = 1; k < 4; k++) d[k] <= d[k-1];
            acc   <= '0;
            tap   <= '0;
            phase <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          tap <= tap + 2'd1;
          if (tap == 2'd3) Y <= acc_sum;
        end
        OUT: begin
          // Y and phase hold through any stall; only an accepted phase advances.
          if (y_ready && phase != 2'd3) begin
            phase <= phase + 2'd1;
            tap   <= '0;
            acc   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
